// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the i2c_arbiter slice: data-path widths, the arbiter
// FSM state encoding (one-hot, same style as the i2c_ctrl master) and a small
// helper that normalises a requested byte count.
// ----------------------------------------------------------------------------
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    // One-hot arbiter states.
    typedef enum logic [5:0] {
        ARB_IDLE      = 6'b000001,
        ARB_ARB       = 6'b000010,
        ARB_LAUNCH    = 6'b000100,
        ARB_WAIT_BUSY = 6'b001000,
        ARB_XFER      = 6'b010000,
        ARB_FINISH    = 6'b100000
    } arb_state_e;

    // A requested count of zero still moves one byte.
    function automatic logic [BYTE_W-1:0] norm_bytes(input logic [BYTE_W-1:0] b);
        return (b == '0) ? BYTE_W'(1) : b;
    endfunction

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. The search starts at index ptr
// and wraps; the first set request bit wins.
//   req   in   N      request vector
//   ptr   in   IDX_W  index with highest priority this round (must be < N)
//   grant out  N      one-hot winner (all zero when no request)
//   idx   out  IDX_W  binary index of the winner
//   found out  1      at least one request was set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_arbiter
// Round-robin arbiter and transaction sequencer sharing one i2c_ctrl master
// between N_REQ requesters. The winner's command is latched into shadow
// registers, the master is launched with a one-cycle m_start, write bytes are
// pulled from the grantee one at a time and read bytes are returned to it.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN (watchdog in WAIT_BUSY/XFER that
// forces FINISH with err after TIMEOUT_CYC cycles without a byte_done edge).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req/req_wr      per-requester level request and direction (1=write)
//   req_addr        packed 7-bit addresses, slice i = requester i
//   req_bytes       packed byte counts (0 means 1)
//   req_wdata       packed next write byte
//   grant           one-hot owner of the master
//   wdata_pull      pulse: grantee presents its next write byte next cycle
//   rdata/rdata_valid  read byte and per-requester valid pulse
//   done/err        end-of-transfer pulse and error flag
//   m_*             interface to i2c_ctrl
//   dbg_state       current FSM state (one-hot)
// ----------------------------------------------------------------------------
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int BUSY_WAIT   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [7*N_REQ-1:0]      req_addr,
    input  logic [8*N_REQ-1:0]      req_bytes,
    input  logic [8*N_REQ-1:0]      req_wdata,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        wdata_pull,
    output logic [7:0]              rdata,
    output logic [N_REQ-1:0]        rdata_valid,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic                    m_start,
    output logic                    m_wr,
    output logic [6:0]              m_addr,
    output logic [7:0]              m_bytes,
    output logic [7:0]              m_wdata,
    input  logic                    m_busy,
    input  logic                    m_byte_done,
    input  logic [7:0]              m_rdata,
    output logic [5:0]              dbg_state
);

    localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [BYTE_W-1:0]   cnt_q, cnt_d;
    logic                sh_wr_q, sh_wr_d;
    logic [ADDR_W-1:0]   sh_addr_q, sh_addr_d;
    logic [BYTE_W-1:0]   sh_bytes_q, sh_bytes_d;
    logic [BYTE_W-1:0]   m_wdata_q, m_wdata_d;
    logic [N_REQ-1:0]    wdata_pull_q, wdata_pull_d;
    logic                cap_q, cap_d;
    logic [BYTE_W-1:0]   rdata_q, rdata_d;
    logic [N_REQ-1:0]    rdata_valid_q, rdata_valid_d;
    logic                bd_prev_q, bd_prev_d;
    logic                busy_prev_q, busy_prev_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic                err_flag_q, err_flag_d;
    logic                fin_pend_q, fin_pend_d;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0]         wd_q, wd_d;
`endif

    logic [N_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic                bd_edge;
    logic                busy_fall;
    logic [BYTE_W-1:0]   cnt_inc;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        sh_wr_d       = sh_wr_q;
        sh_addr_d     = sh_addr_q;
        sh_bytes_d    = sh_bytes_q;
        m_wdata_d     = m_wdata_q;
        wdata_pull_d  = '0;
        cap_d         = |wdata_pull_q;
        rdata_d       = rdata_q;
        rdata_valid_d = '0;
        bd_prev_d     = m_byte_done;
        busy_prev_d   = m_busy;
        wait_cnt_d    = wait_cnt_q;
        err_flag_d    = err_flag_q;
        fin_pend_d    = fin_pend_q;

        // A held byte_done level counts once; only the rising edge matters.
        bd_edge   = m_byte_done & ~bd_prev_q;
        busy_fall = ~m_busy & busy_prev_q;
        cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        // The grantee answered the pull one cycle ago; take its byte now.
        if (cap_q) begin
            m_wdata_d = req_wdata[idx_q*BYTE_W +: BYTE_W];
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d = ARB_ARB;
                end
            end
            ARB_ARB: begin
                if (pick_found) begin
                    grant_d    = pick_grant;
                    idx_d      = pick_idx;
                    ptr_d      = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
                    sh_wr_d    = req_wr[pick_idx];
                    sh_addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    sh_bytes_d = norm_bytes(req_bytes[pick_idx*BYTE_W +: BYTE_W]);
                    m_wdata_d  = req_wdata[pick_idx*BYTE_W +: BYTE_W];
                    cnt_d      = '0;
                    state_d    = ARB_LAUNCH;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LAUNCH: begin
                wait_cnt_d = '0;
                err_flag_d = 1'b0;
                fin_pend_d = 1'b0;
                state_d    = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (m_busy) begin
                    state_d = ARB_XFER;
                end else if (wait_cnt_q == 16'(BUSY_WAIT - 1)) begin
                    err_flag_d = 1'b1;
                    state_d    = ARB_FINISH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ARB_XFER: begin
                if (bd_edge) begin
                    cnt_d = cnt_inc;
                    if (sh_wr_q) begin
                        if (cnt_inc < sh_bytes_q) begin
                            wdata_pull_d = grant_q;
                        end
                    end else if (cnt_inc <= sh_bytes_q) begin
                        rdata_d       = m_rdata;
                        rdata_valid_d = grant_q;
                    end
                end
                // A byte edge coinciding with the busy fall is serviced first,
                // so FINISH is taken one cycle later.
                if (fin_pend_q) begin
                    state_d = ARB_FINISH;
                end else if (busy_fall) begin
                    if (bd_edge) begin
                        fin_pend_d = 1'b1;
                    end else begin
                        state_d = ARB_FINISH;
                    end
                end
            end
            ARB_FINISH: begin
                grant_d    = '0;
                err_flag_d = 1'b0;
                fin_pend_d = 1'b0;
                state_d    = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

`ifdef I2C_ARB_TIMEOUT_EN
        wd_d = '0;
        if (state_q == ARB_WAIT_BUSY || state_q == ARB_XFER) begin
            if (bd_edge) begin
                wd_d = '0;
            end else if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
                wd_d       = wd_q;
                state_d    = ARB_FINISH;
                err_flag_d = 1'b1;
                fin_pend_d = 1'b0;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            idx_q         <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            sh_wr_q       <= 1'b0;
            sh_addr_q     <= '0;
            sh_bytes_q    <= '0;
            m_wdata_q     <= '0;
            wdata_pull_q  <= '0;
            cap_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= '0;
            bd_prev_q     <= 1'b0;
            busy_prev_q   <= 1'b0;
            wait_cnt_q    <= '0;
            err_flag_q    <= 1'b0;
            fin_pend_q    <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            sh_wr_q       <= sh_wr_d;
            sh_addr_q     <= sh_addr_d;
            sh_bytes_q    <= sh_bytes_d;
            m_wdata_q     <= m_wdata_d;
            wdata_pull_q  <= wdata_pull_d;
            cap_q         <= cap_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bd_prev_q     <= bd_prev_d;
            busy_prev_q   <= busy_prev_d;
            wait_cnt_q    <= wait_cnt_d;
            err_flag_q    <= err_flag_d;
            fin_pend_q    <= fin_pend_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q          <= wd_d;
`endif
        end
    end

    // m_start is masked by rst so a launch can never coincide with reset.
    assign m_start     = (state_q == ARB_LAUNCH) & ~rst;
    assign done        = (state_q == ARB_FINISH) ? grant_q : '0;
    assign err         = (state_q == ARB_FINISH) & err_flag_q;
    assign grant       = grant_q;
    assign wdata_pull  = wdata_pull_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign m_wr        = sh_wr_q;
    assign m_addr      = sh_addr_q;
    assign m_bytes     = sh_bytes_q;
    assign m_wdata     = m_wdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: the master side is scripted per test with
// cycle offsets from the observed m_start; expected values are hand-computed.
module tb_i2c_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_wr;
    logic [27:0] req_addr;
    logic [31:0] req_bytes;
    logic [31:0] req_wdata;
    logic [3:0]  grant;
    logic [3:0]  wdata_pull;
    logic [7:0]  rdata;
    logic [3:0]  rdata_valid;
    logic [3:0]  done;
    logic        err;
    logic        m_start;
    logic        m_wr;
    logic [6:0]  m_addr;
    logic [7:0]  m_bytes;
    logic [7:0]  m_wdata;
    logic        m_busy;
    logic        m_byte_done;
    logic [7:0]  m_rdata;
    logic [5:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    i2c_arbiter #(.N_REQ(4), .BUSY_WAIT(4), .TIMEOUT_CYC(4096)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_bytes(req_bytes), .req_wdata(req_wdata), .grant(grant),
        .wdata_pull(wdata_pull), .rdata(rdata), .rdata_valid(rdata_valid),
        .done(done), .err(err), .m_start(m_start), .m_wr(m_wr), .m_addr(m_addr),
        .m_bytes(m_bytes), .m_wdata(m_wdata), .m_busy(m_busy),
        .m_byte_done(m_byte_done), .m_rdata(m_rdata), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle_inputs();
        req = '0; req_wr = '0; req_addr = '0; req_bytes = '0; req_wdata = '0;
        m_busy = 1'b0; m_byte_done = 1'b0; m_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (m_start !== 1'b0) begin bad++; $display("FAIL reset_m_start got=%b want=0", m_start); end
        total++; if (done !== 4'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b/%b want=0000/0", done, err); end
        total++; if (wdata_pull !== 4'b0 || rdata_valid !== 4'b0) begin bad++; $display("FAIL reset_pulses got=%b/%b want=0", wdata_pull, rdata_valid); end
        total++; if (rdata !== 8'h00 || m_wdata !== 8'h00 || m_addr !== 7'h00) begin bad++; $display("FAIL reset_data got=%h/%h/%h want=0", rdata, m_wdata, m_addr); end
        total++; if (dbg_state !== 6'b000001) begin bad++; $display("FAIL reset_state got=%b want=000001", dbg_state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int s = -100; int starts = 0; int pulls = 0; int done_c = -1;
        logic [7:0] e;
        req_wr[0] = 1'b1; req_addr[6:0] = 7'h50; req_bytes[7:0] = 8'd3; req_wdata[7:0] = 8'hA1;
        exp_q.delete(); exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
        req[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (m_start) begin
                starts++; s = c; e = exp_q.pop_front();
                total++; if (m_addr !== 7'h50 || m_wr !== 1'b1 || m_bytes !== 8'd3) begin bad++; $display("FAIL wr_cmd got=%h/%b/%0d want=50/1/3", m_addr, m_wr, m_bytes); end
                total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wr_grant got=%b want=0001", grant); end
                total++; if (m_wdata !== e) begin bad++; $display("FAIL wr_byte0 got=%h want=%h", m_wdata, e); end
            end
            if (wdata_pull[0]) begin
                pulls++;
                req_wdata[7:0] = (pulls == 1) ? 8'hB2 : 8'hC3;
            end
            if (c == s + 2) m_busy = 1'b1;
            m_byte_done = (c == s + 6 || c == s + 12 || c == s + 18);
            if (c == s + 10 || c == s + 16) begin
                e = exp_q.pop_front();
                total++; if (m_wdata !== e) begin bad++; $display("FAIL wr_byte got=%h want=%h", m_wdata, e); end
            end
            if (c == s + 20) m_busy = 1'b0;
            if (done !== 4'b0 && done_c < 0) begin
                done_c = c; req[0] = 1'b0;
                total++; if (done !== 4'b0001 || err !== 1'b0) begin bad++; $display("FAIL wr_done got=%b/%b want=0001/0", done, err); end
            end
        end
        total++; if (starts != 1) begin bad++; $display("FAIL wr_starts got=%0d want=1", starts); end
        total++; if (pulls != 2) begin bad++; $display("FAIL wr_pulls got=%0d want=2", pulls); end
        total++; if (done_c - s != 21) begin bad++; $display("FAIL wr_done_lat got=%0d want=21", done_c - s); end
        idle_inputs();
    endtask

    task automatic test_held_byte_done();
        int s = -100; int pulls = 0; int done_c = -1;
        req_wr[1] = 1'b1; req_addr[13:7] = 7'h21; req_bytes[15:8] = 8'd2; req_wdata[15:8] = 8'h11;
        req[1] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_start) s = c;
            if (wdata_pull != 4'b0) begin
                pulls++; req_wdata[15:8] = 8'h22;
                total++; if (wdata_pull !== 4'b0010) begin bad++; $display("FAIL held_pull_dst got=%b want=0010", wdata_pull); end
            end
            if (c == s + 2) m_busy = 1'b1;
            m_byte_done = (c >= s + 6 && c <= s + 9);
            if (c == s + 12) begin
                total++; if (m_wdata !== 8'h22) begin bad++; $display("FAIL held_wdata got=%h want=22", m_wdata); end
            end
            if (c == s + 14) m_busy = 1'b0;
            if (done !== 4'b0 && done_c < 0) begin done_c = c; req[1] = 1'b0; end
        end
        total++; if (pulls != 1) begin bad++; $display("FAIL held_pulls got=%0d want=1", pulls); end
        total++; if (done_c - s != 15) begin bad++; $display("FAIL held_done_lat got=%0d want=15", done_c - s); end
        idle_inputs();
    endtask

    task automatic test_read();
        int s = -100; int nvalid = 0; int done_c = -1;
        logic [7:0] e;
        req_wr[2] = 1'b0; req_addr[20:14] = 7'h2A; req_bytes[23:16] = 8'd2;
        exp_q.delete(); exp_q.push_back(8'h3C); exp_q.push_back(8'h7E);
        req[2] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_start) begin
                s = c;
                total++; if (m_addr !== 7'h2A || m_wr !== 1'b0 || m_bytes !== 8'd2) begin bad++; $display("FAIL rd_cmd got=%h/%b/%0d want=2a/0/2", m_addr, m_wr, m_bytes); end
            end
            if (rdata_valid != 4'b0) begin
                nvalid++; e = exp_q.pop_front();
                total++; if (rdata_valid !== 4'b0100 || rdata !== e) begin bad++; $display("FAIL rd_data got=%b/%h want=0100/%h", rdata_valid, rdata, e); end
            end
            if (c == s + 2) m_busy = 1'b1;
            m_byte_done = (c == s + 6 || c == s + 10 || c == s + 14);
            if (c == s + 6) m_rdata = 8'h3C;
            if (c == s + 10) m_rdata = 8'h7E;
            if (c == s + 14) begin m_rdata = 8'hFF; m_busy = 1'b0; end
            if (done !== 4'b0 && done_c < 0) begin
                done_c = c; req[2] = 1'b0;
                total++; if (done !== 4'b0100 || err !== 1'b0) begin bad++; $display("FAIL rd_done got=%b/%b want=0100/0", done, err); end
            end
        end
        total++; if (nvalid != 2) begin bad++; $display("FAIL rd_valid_cnt got=%0d want=2", nvalid); end
        total++; if (done_c - s != 16) begin bad++; $display("FAIL rd_done_lat got=%0d want=16", done_c - s); end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        int s = -100;
        req_wr[3] = 1'b1; req_addr[27:21] = 7'h33; req_bytes[31:24] = 8'd4; req_wdata[31:24] = 8'h44;
        req[3] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_start) s = c;
            if (c == s + 2) m_busy = 1'b1;
            m_byte_done = (c == s + 6 || c == s + 10);
            if (c == s + 11) begin rst = 1'b1; req = '0; m_busy = 1'b0; end
            if (c == s + 12) begin
                total++; if (grant !== 4'b0 || m_start !== 1'b0) begin bad++; $display("FAIL mrst_grant got=%b/%b want=0000/0", grant, m_start); end
                total++; if (dbg_state !== 6'b000001) begin bad++; $display("FAIL mrst_state got=%b want=000001", dbg_state); end
                total++; if (m_addr !== 7'h00 || m_bytes !== 8'h00 || done !== 4'b0) begin bad++; $display("FAIL mrst_outs got=%h/%h/%b want=0", m_addr, m_bytes, done); end
                rst = 1'b0;
            end
        end
        total++; if (s < 0) begin bad++; $display("FAIL mrst_start got=none want=start"); end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic [3:0] exp_g[5];
        int s = -100; int starts = 0; int ndone = 0; int last_done = -1;
        logic [3:0] cur;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        cur = 4'b0;
        req_bytes = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (m_start) begin
                s = c;
                cur = (starts < 5) ? exp_g[starts] : 4'b0;
                total++; if (grant !== cur) begin bad++; $display("FAIL rr_grant n=%0d got=%b want=%b", starts, grant, cur); end
                if (last_done >= 0) begin
                    total++; if (c - last_done != 3) begin bad++; $display("FAIL rr_b2b got=%0d want=3", c - last_done); end
                end
                starts++;
            end
            if (c == s + 2) m_busy = 1'b1;
            if (c == s + 4) m_busy = 1'b0;
            if (done !== 4'b0) begin
                total++; if (done !== cur || grant !== cur) begin bad++; $display("FAIL rr_done got=%b/%b want=%b", done, grant, cur); end
                ndone++; last_done = c;
                if (ndone == 5) req = '0;
            end
        end
        total++; if (ndone != 5 || starts != 5) begin bad++; $display("FAIL rr_count got=%0d/%0d want=5/5", ndone, starts); end
        idle_inputs();
    endtask

    task automatic test_no_response();
        int s = -100; int done_c = -1;
        req_wr[1] = 1'b1; req_bytes[15:8] = 8'd0;
        req[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_start) begin
                s = c;
                total++; if (m_bytes !== 8'd1) begin bad++; $display("FAIL nr_bytes0 got=%0d want=1", m_bytes); end
            end
            if (done_c >= 0 && c == done_c + 1) begin
                total++; if (err !== 1'b0 || done !== 4'b0) begin bad++; $display("FAIL nr_pulse_len got=%b/%b want=0/0000", err, done); end
            end
            if (done !== 4'b0 && done_c < 0) begin
                done_c = c; req[1] = 1'b0;
                total++; if (done !== 4'b0010 || err !== 1'b1) begin bad++; $display("FAIL nr_done got=%b/%b want=0010/1", done, err); end
            end
        end
        total++; if (done_c - s != 5) begin bad++; $display("FAIL nr_lat got=%0d want=5", done_c - s); end
        idle_inputs();
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int s = -100; int done_c = -1;
        req_wr[0] = 1'b0; req_bytes[7:0] = 8'd2;
        req[0] = 1'b1;
        for (int c = 0; c < 4300; c++) begin
            @(negedge clk);
            if (m_start) s = c;
            if (c == s + 2) m_busy = 1'b1;
            if (done !== 4'b0 && done_c < 0) begin
                done_c = c; req[0] = 1'b0; m_busy = 1'b0;
                total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err); end
            end
        end
        total++; if (done_c - s < 4096 || done_c - s > 4098) begin bad++; $display("FAIL to_lat got=%0d want=4096..4098", done_c - s); end
        idle_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_held_byte_done();
        test_read();
        test_mid_reset();
        test_contention();
        test_no_response();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
